ram_bist_ctrl: RTL and testbench
================================

# ram_bist_ctrl

Built-in self-test initiator for the 1K×8 single-port `ram` block. On a start pulse it drives the RAM's address/data_in/write/select pins to fill every location with the pattern (2·addr) mod 2^DW. It then reads every location back, compares it against the expected value, and reports pass/fail, an error count and the first failing address. It sits beside `ram` in place of bench stimulus and is the synthesizable master for that interface.

## Interface
- AW, 10, RAM address width (depth 2^AW)
- DW, 8, RAM data width
- RD_LAT, 1, cycles from address/select presented (write=0) to valid data_out; legal 0..3
- RAND_READS, 20, number of random-address reads (only with macro)
- LFSR_SEED, 10'd35, random-phase LFSR seed (zero is replaced by 1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; honoured only in IDLE
- ram_data_out  in  DW  data from RAM
- ram_data_in  out  DW  write data to RAM
- ram_address  out  AW  RAM address
- ram_write  out  1  RAM write strobe
- ram_select  out  1  RAM chip select
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at test end
- pass  out  1  valid from done until next start: 1 iff err_cnt==0
- err_cnt  out  AW+1  saturating mismatch count
- fail_addr  out  AW  address of the first mismatch; 0 if none

## Operation
- States: IDLE → WRITE → READ → (RAND) → DRAIN → DONE → IDLE.
- IDLE: RAM pins are idle (select=0, write=0, address/data_in hold last value); start clears err_cnt, fail_addr and pass, then enters WRITE.
- WRITE: for addr 0..2^AW−1, one per cycle: select=1, write=1, data_in=(addr<<1) truncated to DW. After the last address the block enters READ with addr=0.
- READ: for addr 0..2^AW−1, one per cycle: select=1, write=0. The expected value and address are piped RD_LAT stages. The block compares ram_data_out with the expected value at the pipe output.
- Mismatch: err_cnt increments, saturating at 2^AW. fail_addr is captured only on the first mismatch.
- DRAIN: select=0, write=0 for RD_LAT cycles so in-flight compares complete; then DONE.
- DONE: done=1 for one cycle, pass=(err_cnt==0). The next state is IDLE with busy=0.
- start while busy: ignored, no restart.
- rst_n low at any time, including mid-WRITE: immediate return to IDLE. RAM contents are not restored.

## Timing
- Reset values: ram_data_in=0, ram_address=0, ram_write=0, ram_select=0, busy=0, done=0, pass=0, err_cnt=0, fail_addr=0.
- All outputs are registered. The first write appears the cycle after start is sampled.
- Total latency from start to done (without macro): 2·2^AW + RD_LAT + 1 cycles. This is 2050 for the defaults.
- Address wrap-around: the counter is AW+1 bits, and its MSB marks phase end. The block never issues address 2^AW.
- RD_LAT=0: compare happens in the same cycle against combinational data_out; DRAIN is skipped.

## Configuration
- RAM_BIST_LFSR_EN defined: a RAND phase runs after READ. It issues RAND_READS reads at addresses from a 10-bit Fibonacci LFSR (x^10+x^7+1), seeded with LFSR_SEED and advanced once per read. The expected value is (lfsr<<1) mod 2^DW. Mismatches count as in READ. Latency grows by RAND_READS.
- RAM_BIST_LFSR_EN undefined: there is no RAND state and no LFSR logic; READ goes straight to DRAIN.

## Structure
- Package ram_bist_pkg holds the state enum (IDLE, WRITE, READ, RAND, DRAIN, DONE) and the pattern function expected(addr).
- Sub-module ram_bist_lfsr: 10-bit LFSR with seed load and step enable. It is instantiated only under the macro.
- The compare pipeline stays in the top module.

## Test plan
- Reset then start with a behavioural `ram` model. Required response: 1024 writes with data_in at addr 5 = 10 and at addr 200 = 144. done pulses at cycle 2050 with pass=1 and err_cnt=0.
- Model forced to corrupt addr 300 (returns 0). Required response: err_cnt=1, fail_addr=300, pass=0.
- Model with stuck data bit 0 = 1. Required response: err_cnt=1024 (every expected value is even), fail_addr=0.
- Assert rst_n low at write addr 512, then start again. Required response: outputs at reset values, then a full clean run with pass=1.
- Pulse start at cycle 100 of a run. Required response: ignored, with done still at cycle 2050.
- With RAM_BIST_LFSR_EN defined and LFSR_SEED=35: the first random address is 35, followed by 20 reads. done arrives at cycle 2070 with pass=1.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and the fill pattern for the RAM BIST controller.
// The RAND state only exists when RAM_BIST_LFSR_EN is defined.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef RAM_BIST_LFSR_EN
    RAND,
`endif
    DRAIN,
    DONE
  } state_t;

  // Callers truncate the result to the RAM data width.
  function automatic logic [31:0] expected(input logic [31:0] addr);
    return addr << 1;
  endfunction

endpackage

// File: rtl/ram_bist_lfsr.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) with seed load and step enable.
// It provides the random read addresses when RAM_BIST_LFSR_EN is defined.
module ram_bist_lfsr #(
  parameter logic [9:0] SEED = 10'd35
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [9:0] value
);

  // An all-zero state would lock up, so a zero seed is replaced by 1.
  localparam logic [9:0] SEED_NZ = (SEED == 10'd0) ? 10'd1 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= SEED_NZ;
    else if (load)
      value <= SEED_NZ;
    else if (step)
      value <= {value[8:0], value[9] ^ value[6]};
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST master for the single-port ram: fill with 2*addr, read back, count mismatches.
// Define RAM_BIST_LFSR_EN to append an LFSR-addressed random read phase.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
`ifdef RAM_BIST_LFSR_EN
  ,
  parameter int         RAND_READS = 20,
  parameter logic [9:0] LFSR_SEED  = 10'd35
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] ram_data_out,
  output logic [DW-1:0] ram_data_in,
  output logic [AW-1:0] ram_address,
  output logic          ram_write,
  output logic          ram_select,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] fail_addr
);

  localparam logic [AW:0] ERR_MAX = {1'b1, {AW{1'b0}}};

  state_t        state, state_nxt;
  logic [AW:0]   cnt, cnt_nxt, cnt_inc;
  logic          sel_nxt, wr_nxt, done_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] din_nxt;
  logic          mismatch;

  logic [RD_LAT:0] pipe_vld;
  logic [DW-1:0]   pipe_exp  [RD_LAT+1];
  logic [AW-1:0]   pipe_addr [RD_LAT+1];

`ifdef RAM_BIST_LFSR_EN
  logic       lfsr_step;
  logic [9:0] lfsr_val;

  ram_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == IDLE && start),
    .step  (lfsr_step),
    .value (lfsr_val)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The *_nxt pin values are registered, so each state describes the cycle that follows it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + 1'b1;
    sel_nxt   = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = ram_address;
    din_nxt   = ram_data_in;
    done_nxt  = 1'b0;
`ifdef RAM_BIST_LFSR_EN
    lfsr_step = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
          cnt_nxt   = '0;
          sel_nxt   = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = '0;
          din_nxt   = DW'(expected(32'd0));
        end
      end
      WRITE: begin
        sel_nxt = 1'b1;
        if (cnt_inc[AW]) begin
          state_nxt = READ;
          cnt_nxt   = '0;
          addr_nxt  = '0;
        end else begin
          wr_nxt   = 1'b1;
          cnt_nxt  = cnt_inc;
          addr_nxt = cnt_inc[AW-1:0];
          din_nxt  = DW'(expected(32'(cnt_inc)));
        end
      end
      READ: begin
        cnt_nxt = '0;
        if (!cnt_inc[AW]) begin
          sel_nxt  = 1'b1;
          cnt_nxt  = cnt_inc;
          addr_nxt = cnt_inc[AW-1:0];
        end else begin
`ifdef RAM_BIST_LFSR_EN
          state_nxt = RAND;
          sel_nxt   = 1'b1;
          addr_nxt  = AW'(lfsr_val);
          lfsr_step = 1'b1;
`else
          state_nxt = (RD_LAT == 0) ? DONE : DRAIN;
`endif
        end
      end
`ifdef RAM_BIST_LFSR_EN
      RAND: begin
        if (cnt_inc == (AW+1)'(RAND_READS)) begin
          cnt_nxt   = '0;
          state_nxt = (RD_LAT == 0) ? DONE : DRAIN;
        end else begin
          sel_nxt   = 1'b1;
          cnt_nxt   = cnt_inc;
          addr_nxt  = AW'(lfsr_val);
          lfsr_step = 1'b1;
        end
      end
`endif
      DRAIN: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == (AW+1)'(RD_LAT))
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0 lines up with the read on the pins; stage RD_LAT lines up with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_exp[i]  <= '0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= sel_nxt & ~wr_nxt;
      pipe_exp[0]  <= DW'(expected(32'(addr_nxt)));
      pipe_addr[0] <= addr_nxt;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign mismatch = pipe_vld[RD_LAT] && (ram_data_out != pipe_exp[RD_LAT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_select  <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
      fail_addr   <= '0;
    end else begin
      ram_select  <= sel_nxt;
      ram_write   <= wr_nxt;
      ram_address <= addr_nxt;
      ram_data_in <= din_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= done_nxt;
      if (state == IDLE && start) begin
        err_cnt   <= '0;
        fail_addr <= '0;
        pass      <= 1'b0;
      end else if (mismatch) begin
        if (err_cnt != ERR_MAX)
          err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0)
          fail_addr <= pipe_addr[RD_LAT];
      end
      if (done_nxt)
        pass <= (err_cnt == '0);
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl against a behavioural ram with injectable faults.
// Also covers the RAND phase when RAM_BIST_LFSR_EN is defined.
module tb_ram_bist_ctrl;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;
`ifdef RAM_BIST_LFSR_EN
  localparam int NRAND  = 20;
`else
  localparam int NRAND  = 0;
`endif
  localparam int EXP_LAT = 2 * DEPTH + RD_LAT + 1 + NRAND;
  localparam int LIMIT   = EXP_LAT + 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] ram_data_out = '0;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_address;
  logic          ram_write, ram_select, busy, done, pass;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] fail_addr;

  int checks = 0;
  int errors = 0;

  // ram model state and fault injection
  logic [DW-1:0] mem [DEPTH];
  int            corrupt_addr = -1;
  logic [DW-1:0] stuck_mask = '0;
  logic [DW-1:0] stuck_val  = '0;
  logic          clr_counts = 1'b0;
  int            wr_count = 0, rd_count = 0, bad_writes = 0;
  logic [DW-1:0] w5 = '0, w200 = '0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ram_data_out (ram_data_out),
    .ram_data_in  (ram_data_in),
    .ram_address  (ram_address),
    .ram_write    (ram_write),
    .ram_select   (ram_select),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .fail_addr    (fail_addr)
  );

  function automatic logic [DW-1:0] faultRead(input int a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = (a == corrupt_addr) ? '0 : d;
    return (r & ~stuck_mask) | (stuck_val & stuck_mask);
  endfunction

  // One-cycle synchronous-read ram, plus write bookkeeping against the fill rule.
  always @(posedge clk) begin
    if (clr_counts) begin
      wr_count   <= 0;
      rd_count   <= 0;
      bad_writes <= 0;
      w5         <= '1;
      w200       <= '1;
    end else if (ram_select) begin
      if (ram_write) begin
        mem[ram_address] <= ram_data_in;
        wr_count <= wr_count + 1;
        if (ram_data_in != DW'(2 * int'(ram_address)))
          bad_writes <= bad_writes + 1;
        if (ram_address == AW'(5))   w5   <= ram_data_in;
        if (ram_address == AW'(200)) w200 <= ram_data_in;
      end else begin
        ram_data_out <= faultRead(int'(ram_address), mem[ram_address]);
        rd_count <= rd_count + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expect_v);
    checks++;
    if (observed !== expect_v) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expect_v);
    end
  endtask

  // Reference: walk the read order the spec defines and apply the fault rules.
  task automatic computeExpected(output int exp_err, output int exp_fail);
    logic [DW-1:0] e;
    exp_err  = 0;
    exp_fail = 0;
    for (int a = 0; a < DEPTH; a++) begin
      e = DW'(2 * a);
      if (faultRead(a, e) != e) begin
        if (exp_err == 0) exp_fail = a;
        exp_err++;
      end
    end
`ifdef RAM_BIST_LFSR_EN
    begin
      logic [9:0] v;
      v = 10'd35;
      for (int k = 0; k < NRAND; k++) begin
        e = DW'(2 * int'(v));
        if (faultRead(int'(v), e) != e) begin
          if (exp_err == 0) exp_fail = int'(v);
          exp_err++;
        end
        v = {v[8:0], v[9] ^ v[6]};
      end
    end
`endif
    if (exp_err > DEPTH) exp_err = DEPTH;
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_din"},   32'(ram_data_in), 0);
    checkOutput({name, "_addr"},  32'(ram_address), 0);
    checkOutput({name, "_wr"},    32'(ram_write), 0);
    checkOutput({name, "_sel"},   32'(ram_select), 0);
    checkOutput({name, "_busy"},  32'(busy), 0);
    checkOutput({name, "_done"},  32'(done), 0);
    checkOutput({name, "_pass"},  32'(pass), 0);
    checkOutput({name, "_err"},   32'(err_cnt), 0);
    checkOutput({name, "_faddr"}, 32'(fail_addr), 0);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start      = 1'b1;
    clr_counts = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    clr_counts = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int corrupt, input int mask,
                               input int val, input int restart_at);
    int exp_err, exp_fail, cyc;
    corrupt_addr = corrupt;
    stuck_mask   = DW'(mask);
    stuck_val    = DW'(val);
    computeExpected(exp_err, exp_fail);
    pulseStart();
    cyc = 0;
    checkOutput({name, "_busy0"},  32'(busy), 1);
    checkOutput({name, "_first_wr"}, {29'd0, ram_select, ram_write, 1'b0} | 32'(ram_address), 32'd6);
    while (!done && cyc < LIMIT) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
    end
    start = 1'b0;
    checkOutput({name, "_done_cycle"}, 32'(cyc), 32'(EXP_LAT));
    checkOutput({name, "_err_cnt"},    32'(err_cnt), 32'(exp_err));
    checkOutput({name, "_fail_addr"},  32'(fail_addr), 32'(exp_fail));
    checkOutput({name, "_pass"},       32'(pass), 32'(exp_err == 0));
    checkOutput({name, "_busy_end"},   32'(busy), 0);
    checkOutput({name, "_writes"},     32'(wr_count), 32'(DEPTH));
    checkOutput({name, "_reads"},      32'(rd_count), 32'(DEPTH + NRAND));
    checkOutput({name, "_bad_writes"}, 32'(bad_writes), 0);
    checkOutput({name, "_w5"},         32'(w5), 10);
    checkOutput({name, "_w200"},       32'(w200), 144);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, 32'(done), 0);
    checkOutput({name, "_pass_hold"},  32'(pass), 32'(exp_err == 0));
  endtask

  task automatic resetMidWrite();
    int cyc;
    corrupt_addr = -1;
    stuck_mask   = '0;
    pulseStart();
    cyc = 0;
    while (!(ram_write && ram_address == AW'(512)) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midreset_reach512", 32'(ram_address), 512);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_stays_idle", {30'd0, busy, ram_select}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("clean", -1, 0, 0, -1);
    applyStimulus("corrupt300", 300, 0, 0, -1);
    applyStimulus("stuck0", -1, 1, 1, -1);
    resetMidWrite();
    applyStimulus("after_reset", -1, 0, 0, -1);
    applyStimulus("restart100", -1, 0, 0, 100);

    for (int r = 0; r < 4; r++) begin
      int c, m, v, rs;
      c  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1;
      m  = ($urandom_range(0, 2) != 0) ? (1 << $urandom_range(0, DW - 1)) : 0;
      v  = int'($urandom_range(0, 255));
      rs = int'($urandom_range(1, EXP_LAT - 5));
      applyStimulus($sformatf("rand%0d", r), c, m, v, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
